// File: rtl/timebase_ctrl.sv
// Run/pause/clear sequencer around a single prescaler that produces a one-cycle
// tick, a 50% duty divided clock and a wrapping count of elapsed ticks.
module timebase_ctrl #(
  parameter int unsigned DIV = 10_000_000,
  parameter int unsigned CW  = 24,
  parameter int unsigned EW  = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  output logic          tick,
  output logic          div_clock,
  output logic          running,
  output logic [EW-1:0] elapsed
);

  localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRESC_HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] presc_q;
  logic          tick_q;
  logic          div_q;
  logic          running_q;
  logic [EW-1:0] elapsed_q;

  // Priority reset > clear > stop > start; stop checked before the wrap so a
  // stop on the last prescaler value holds DIV-1 and defers the tick.
  always_ff @(posedge clock) begin
    tick_q <= 1'b0;
    if (reset || clear) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      div_q     <= 1'b0;
      running_q <= 1'b0;
      elapsed_q <= '0;
    end else begin
      case (state_q)
        IDLE, PAUSED: begin
          if (start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q   <= '0;
            tick_q    <= 1'b1;
            div_q     <= 1'b0;
            elapsed_q <= elapsed_q + EW'(1);
          end else begin
            presc_q <= presc_q + CW'(1);
            if (presc_q == PRESC_HALF) div_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          presc_q   <= '0;
          div_q     <= 1'b0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign tick      = tick_q;
  assign div_clock = div_q;
  assign running   = running_q;
  assign elapsed   = elapsed_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Scoreboard bench for timebase_ctrl: a driver pushes model predictions, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_timebase_ctrl;

  localparam int unsigned DIV = 10;
  localparam int unsigned CW  = 8;
  localparam int unsigned EW  = 4;

  typedef struct packed {
    logic          tick;
    logic          divc;
    logic          run;
    logic [EW-1:0] el;
  } exp_t;

  bit clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic tick, div_clock, running;
  logic [EW-1:0] elapsed;

  int checks = 0;
  int failures = 0;

  exp_t          exp_q[$];
  logic [EW-1:0] tick_q[$];

  // Reference model: count of advancing RUN edges since the last clear/reset.
  bit          m_run = 1'b0;
  int unsigned m_n   = 0;

  timebase_ctrl #(.DIV(DIV), .CW(CW), .EW(EW)) dut (
    .clock(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .tick(tick), .div_clock(div_clock), .running(running), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_step(input logic s, input logic p,
                                      input logic c, input logic r);
    exp_t e;
    bit   adv = 1'b0;
    if (r || c) begin
      m_run = 1'b0;
      m_n   = 0;
    end else if (m_run && p) begin
      m_run = 1'b0;
    end else if (m_run) begin
      m_n = m_n + 1;
      adv = 1'b1;
    end else if (s) begin
      m_run = 1'b1;
    end
    e.tick = adv && (m_n % DIV == 0);
    e.divc = (m_n % DIV) >= DIV / 2;
    e.run  = m_run;
    e.el   = EW'((m_n / DIV) % (1 << EW));
    return e;
  endfunction

  // One clock edge with the given command inputs.
  task automatic cyc(input logic s, input logic p, input logic c, input logic r);
    exp_t e;
    start = s; stop = p; clear = c; reset = r;
    e = model_step(s, p, c, r);
    exp_q.push_back(e);
    if (e.tick) tick_q.push_back(e.el);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle presents a full output word; ticks also carry elapsed.
  always @(negedge clk) begin
    exp_t e;
    logic [EW-1:0] et;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({tick, div_clock, running, elapsed} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got tick=%b div=%b run=%b el=%0d want tick=%b div=%b run=%b el=%0d",
                 $time, tick, div_clock, running, elapsed, e.tick, e.divc, e.run, e.el);
      end
    end
    if (tick === 1'b1) begin
      checks++;
      if (tick_q.size() == 0) begin
        failures++;
        $display("FAIL tick_event t=%0t got unexpected tick el=%0d want no tick", $time, elapsed);
      end else begin
        et = tick_q.pop_front();
        if (elapsed !== et) begin
          failures++;
          $display("FAIL tick_elapsed t=%0t got %0d want %0d", $time, elapsed, et);
        end
      end
    end
  end

  initial begin
    // Reset and idle
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(50);
    // Free run, then stop at edge 23, resume at edge 63
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(22);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(39);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    // Stop on the wrap edge, resume at edge 20
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    // Clear beats stop and start; start again while running is ignored
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(30);
    // start+stop together in RUN pauses, in PAUSED resumes
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(12);
    // Elapsed wrap over 17+ ticks, then mid-run reset
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(17 * DIV + 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    // Randomized command traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 599) == 0));
    end
    idle(2 * DIV);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || tick_q.size() != 0) begin
      failures++;
      $display("FAIL drain got exp=%0d ticks=%0d pending want 0", exp_q.size(), tick_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
